// File: rtl/operand_issue_pkg.sv
// Shared constants for the operand issue block: instruction classes, opcode/funct3
// values and the FSM state encoding.
package operand_issue_pkg;

    // Instruction class codes carried on itype_i
    localparam logic [4:0] RTYPE = 5'd1;
    localparam logic [4:0] ITYPE = 5'd2;
    localparam logic [4:0] STYPE = 5'd3;
    localparam logic [4:0] BTYPE = 5'd4;
    localparam logic [4:0] UTYPE = 5'd5;
    localparam logic [4:0] LTYPE = 5'd6;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [2:0] F3_SLLI   = 3'b001;
    localparam logic [2:0] F3_SRXI   = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_READ   = 2'd1;
    localparam logic [1:0] ST_SETUP  = 2'd2;
    localparam logic [1:0] ST_STROBE = 2'd3;

    function automatic logic is_shift_imm(input logic [2:0] funct3);
        return (funct3 == F3_SLLI) || (funct3 == F3_SRXI);
    endfunction

endpackage

// File: rtl/operand_issue_imm_gen.sv
// Combinational RV32I immediate decoder; immediates that do not belong to the
// given instruction class are forced to zero.
module operand_issue_imm_gen
    import operand_issue_pkg::*;
(
    input  logic [31:0] ir_i,
    input  logic [4:0]  itype_i,
    output logic [31:0] imm_i_o,
    output logic [31:0] imm_s_o,
    output logic [31:0] imm_b_o,
    output logic [31:0] imm_u_o,
    output logic [4:0]  shamt_o
);

    logic use_i;

    assign use_i = (itype_i == ITYPE) || (itype_i == LTYPE);

    assign imm_i_o = use_i ? {{20{ir_i[31]}}, ir_i[31:20]} : 32'd0;
    assign imm_s_o = (itype_i == STYPE) ? {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]} : 32'd0;
    assign imm_b_o = (itype_i == BTYPE)
                   ? {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0}
                   : 32'd0;
    assign imm_u_o = (itype_i == UTYPE) ? {ir_i[31:12], 12'd0} : 32'd0;
    assign shamt_o = (itype_i == ITYPE) ? ir_i[24:20] : 5'd0;

endmodule

// File: rtl/operand_issue.sv
// Operand issue FSM: reads the register file, builds the ALU operands, holds them
// for SETUP_CYCLES and then pulses the readin strobes for one cycle.
module operand_issue
    import operand_issue_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int SETUP_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [31:0]     ir_i,
    input  logic [4:0]      itype_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [4:0]      rf_raddr_a_o,
    output logic [4:0]      rf_raddr_b_o,
    input  logic [XLEN-1:0] rf_rdata_a_i,
    input  logic [XLEN-1:0] rf_rdata_b_i,
    output logic [XLEN-1:0] readd_a_o,
    output logic [XLEN-1:0] readd_b_o,
    output logic [XLEN-1:0] readd_pass_o,
    output logic            readin_a_o,
    output logic            readin_b_o,
    output logic            readin_pass_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int CNT_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETUP_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]     ir_q;
    logic [4:0]      itype_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] opa_q, opb_q, opp_q;
    logic [XLEN-1:0] opa_d, opb_d, opp_d;
    logic            strobe_q, done_q;
    logic            accept;

    logic [31:0] imm_i, imm_s, imm_b, imm_u;
    logic [4:0]  shamt;

    operand_issue_imm_gen u_imm_gen (
        .ir_i    (ir_q),
        .itype_i (itype_q),
        .imm_i_o (imm_i),
        .imm_s_o (imm_s),
        .imm_b_o (imm_b),
        .imm_u_o (imm_u),
        .shamt_o (shamt)
    );

    assign accept = (state_q == ST_IDLE) && start_i && !reset;

    // The RF has one cycle of read latency, so the address must be presented in
    // the accepting cycle straight from ir_i, then held from the captured copy.
    always_comb begin
        rf_raddr_a_o = ir_q[19:15];
        rf_raddr_b_o = ir_q[24:20];
        if (state_q == ST_IDLE) begin
            rf_raddr_a_o = accept ? ir_i[19:15] : 5'd0;
            rf_raddr_b_o = accept ? ir_i[24:20] : 5'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_READ;
            ST_READ:   state_d = ST_SETUP;
            ST_SETUP:  if (cnt_q == '0) state_d = ST_STROBE;
            ST_STROBE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        opa_d = '0;
        opb_d = '0;
        opp_d = '0;
        case (itype_q)
            RTYPE: begin
                opa_d = rf_rdata_a_i;
                opb_d = rf_rdata_b_i;
            end
            ITYPE: begin
                opa_d = rf_rdata_a_i;
                opb_d = is_shift_imm(ir_q[14:12]) ? {27'd0, shamt} : imm_i;
            end
            LTYPE: begin
                opa_d = rf_rdata_a_i;
                opb_d = imm_i;
            end
            STYPE: begin
                opa_d = rf_rdata_a_i;
                opb_d = imm_s;
                opp_d = rf_rdata_b_i;
            end
            BTYPE: begin
                opa_d = rf_rdata_a_i;
                opb_d = rf_rdata_b_i;
                opp_d = imm_b;
            end
            UTYPE: opa_d = (ir_q[6:0] == OPC_AUIPC) ? pc_q + imm_u : imm_u;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ir_q     <= '0;
            itype_q  <= '0;
            pc_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            opp_q    <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            strobe_q <= (state_d == ST_STROBE);
            done_q   <= (state_q == ST_STROBE);
            if (accept) begin
                ir_q    <= ir_i;
                itype_q <= itype_i;
                pc_q    <= pc_i;
            end
            if (state_q == ST_READ) begin
                opa_q <= opa_d;
                opb_q <= opb_d;
                opp_q <= opp_d;
                cnt_q <= CNT_LOAD;
            end else if (state_q == ST_SETUP && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign readd_a_o     = opa_q;
    assign readd_b_o     = opb_q;
    assign readd_pass_o  = opp_q;
    assign readin_a_o    = strobe_q;
    assign readin_b_o    = strobe_q;
    assign readin_pass_o = strobe_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;

endmodule
